wb_stage: RTL and testbench

//  Write-back stage of the 5-stage pipeline: the writer end of the GPR write port.
//  - Latches the MEM/WB payload and selects the result: ALU, load (sized and extended) or link (PC+8).
//  - Drives reg_write / num_write / data_write into the register file.
//  - Commits each instruction exactly once and counts retired instructions.

---
 rtl/wb_stage.sv | 184 ++++++++++++++++++
 tb/tb_wb_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : write-back stage of the 5-stage pipeline (writer end of the GPR
// write port).
//
// Latches the MEM/WB payload, forms the write-back result (ALU, sized and
// extended load, or link address), drives the register-file write port and
// counts retired instructions. Each instruction commits exactly once, even
// when it is held in WB across a multi-cycle stall.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, decode-side forwarding ports are added. Decode operands
//   then see the value being committed in the same cycle. When undefined,
//   those ports do not exist, and decode sees a write only after its commit
//   edge.
//
// Parameters
//   CNT_W     width of the retired-instruction counter
//   LINK_OFS  offset added to the instruction PC for link writes
//
// Ports
//   i_clock            rising-edge clock
//   i_resetn           synchronous active-low reset
//   i_mem_valid        MEM stage presents a valid instruction
//   i_mem_instr[31:0]  instruction word, opcode in [31:26]
//   i_mem_alu_result   ALU result / effective address
//   i_mem_load_data    raw aligned word from data memory
//   i_mem_pc           PC of the instruction
//   i_mem_dst[4:0]     destination register number
//   i_mem_reg_write    instruction writes a GPR
//   i_mem_wb_sel[1:0]  00 ALU, 01 load, 10 link, 11 reserved (writes 0)
//   i_stall            hold all WB registers
//   i_flush            squash the instruction entering WB (beats stall)
//   i_rs_num/i_rt_num  decode operand numbers        (WB_BYPASS_EN only)
//   i_gpr_a/i_gpr_b    register-file read data       (WB_BYPASS_EN only)
//   o_a_fwd/o_b_fwd    forwarded decode operands     (WB_BYPASS_EN only)
//   o_reg_write        GPR write enable
//   o_num_write        GPR write index (0 when WB is empty)
//   o_data_write       GPR write data  (0 when WB is empty)
//   o_wb_valid         WB register holds a valid instruction
//   o_retired_count    committed instruction count, wraps mod 2^CNT_W
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] LINK_OFS = 32'd8
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic             i_mem_valid,
    input  logic [31:0]      i_mem_instr,
    input  logic [31:0]      i_mem_alu_result,
    input  logic [31:0]      i_mem_load_data,
    input  logic [31:0]      i_mem_pc,
    input  logic [4:0]       i_mem_dst,
    input  logic             i_mem_reg_write,
    input  logic [1:0]       i_mem_wb_sel,
    input  logic             i_stall,
    input  logic             i_flush,
`ifdef WB_BYPASS_EN
    input  logic [4:0]       i_rs_num,
    input  logic [4:0]       i_rt_num,
    input  logic [31:0]      i_gpr_a,
    input  logic [31:0]      i_gpr_b,
    output logic [31:0]      o_a_fwd,
    output logic [31:0]      o_b_fwd,
`endif
    output logic             o_reg_write,
    output logic [4:0]       o_num_write,
    output logic [31:0]      o_data_write,
    output logic             o_wb_valid,
    output logic [CNT_W-1:0] o_retired_count
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    // WB pipeline registers
    logic             r_valid;
    logic             r_committed;
    logic             r_reg_write;
    logic [4:0]       r_dst;
    logic [31:0]      r_data;
    logic [CNT_W-1:0] r_count;

    logic [5:0]       w_opcode;
    logic [1:0]       w_offset;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_val;
    logic [31:0]      w_result;
    logic             w_retire;
    logic             w_unused_instr;

    assign w_opcode       = i_mem_instr[31:26];
    assign w_offset       = i_mem_alu_result[1:0];
    assign w_unused_instr = ^i_mem_instr[25:0];

    // Little-endian lane select; halfwords ignore address bit 0.
    always_comb begin
        w_byte = i_mem_load_data[7:0];
        case (w_offset)
            2'd0:    w_byte = i_mem_load_data[7:0];
            2'd1:    w_byte = i_mem_load_data[15:8];
            2'd2:    w_byte = i_mem_load_data[23:16];
            default: w_byte = i_mem_load_data[31:24];
        endcase
        w_half = w_offset[1] ? i_mem_load_data[31:16] : i_mem_load_data[15:0];
    end

    // Any opcode that is not a sub-word load takes the full word.
    always_comb begin
        w_load_val = i_mem_load_data;
        case (w_opcode)
            OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_val = {24'h0, w_byte};
            OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_val = {16'h0, w_half};
            default: w_load_val = i_mem_load_data;
        endcase
    end

    always_comb begin
        w_result = 32'h0;
        case (i_mem_wb_sel)
            SEL_ALU:  w_result = i_mem_alu_result;
            SEL_LOAD: w_result = w_load_val;
            SEL_LINK: w_result = i_mem_pc + LINK_OFS;
            default:  w_result = 32'h0;
        endcase
    end

    // An instruction retires on the first edge it spends in WB; committed
    // masks it on every later edge of a stall.
    assign w_retire = r_valid & ~r_committed;

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_valid     <= 1'b0;
            r_committed <= 1'b0;
            r_reg_write <= 1'b0;
            r_dst       <= 5'd0;
            r_data      <= 32'h0;
            r_count     <= '0;
        end else begin
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end

            if (i_flush) begin
                r_valid     <= 1'b0;
                r_committed <= 1'b0;
            end else if (i_stall) begin
                if (r_valid) begin
                    r_committed <= 1'b1;
                end
            end else begin
                r_valid     <= i_mem_valid;
                r_committed <= 1'b0;
                r_reg_write <= i_mem_reg_write;
                r_dst       <= i_mem_dst;
                r_data      <= w_result;
            end
        end
    end

    // $0 writes are dropped here so the register file never sees them.
    assign o_reg_write     = r_valid & r_reg_write & (r_dst != 5'd0) & ~r_committed;
    assign o_num_write     = r_valid ? r_dst  : 5'd0;
    assign o_data_write    = r_valid ? r_data : 32'h0;
    assign o_wb_valid      = r_valid;
    assign o_retired_count = r_count;

`ifdef WB_BYPASS_EN
    // num_write==0 never coincides with reg_write, so $0 reads pass gpr as-is.
    assign o_a_fwd = (o_reg_write && (o_num_write == i_rs_num)) ? o_data_write : i_gpr_a;
    assign o_b_fwd = (o_reg_write && (o_num_write == i_rt_num)) ? o_data_write : i_gpr_b;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    logic        clock;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_instr;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc;
    logic [4:0]  mem_dst;
    logic        mem_reg_write;
    logic [1:0]  mem_wb_sel;
    logic        stall;
    logic        flush;
    logic        reg_write;
    logic [4:0]  num_write;
    logic [31:0] data_write;
    logic        wb_valid;
    logic [31:0] retired_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic [31:0] gpr_a;
    logic [31:0] gpr_b;
    logic [31:0] a_fwd;
    logic [31:0] b_fwd;
`endif

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_cnt;

    wb_stage #(.CNT_W(32), .LINK_OFS(32'd8)) dut (
        .i_clock          (clock),
        .i_resetn         (resetn),
        .i_mem_valid      (mem_valid),
        .i_mem_instr      (mem_instr),
        .i_mem_alu_result (mem_alu_result),
        .i_mem_load_data  (mem_load_data),
        .i_mem_pc         (mem_pc),
        .i_mem_dst        (mem_dst),
        .i_mem_reg_write  (mem_reg_write),
        .i_mem_wb_sel     (mem_wb_sel),
        .i_stall          (stall),
        .i_flush          (flush),
`ifdef WB_BYPASS_EN
        .i_rs_num         (rs_num),
        .i_rt_num         (rt_num),
        .i_gpr_a          (gpr_a),
        .i_gpr_b          (gpr_b),
        .o_a_fwd          (a_fwd),
        .o_b_fwd          (b_fwd),
`endif
        .o_reg_write      (reg_write),
        .o_num_write      (num_write),
        .o_data_write     (data_write),
        .o_wb_valid       (wb_valid),
        .o_retired_count  (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc, input logic [4:0] dst,
                         input logic rw, input logic [1:0] sel);
        mem_valid      = v;
        mem_instr      = {op, 26'h0};
        mem_alu_result = alu;
        mem_load_data  = ld;
        mem_pc         = pc;
        mem_dst        = dst;
        mem_reg_write  = rw;
        mem_wb_sel     = sel;
    endtask

    task automatic test_reset;
        resetn = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 6'h00, 32'h11, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00);
        tick; tick;
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL rst_reg_write: got %b want 0", reg_write); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
        n_cmp++; if (retired_count !== 32'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", retired_count); end
        n_cmp++; if (num_write !== 5'd0) begin n_bad++; $display("FAIL rst_num_write: got %0d want 0", num_write); end
        n_cmp++; if (data_write !== 32'h0) begin n_bad++; $display("FAIL rst_data_write: got %h want 0", data_write); end
        resetn = 1'b1;
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        exp_cnt = 32'd0;
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL rst_release_count: got %0d want %0d", retired_count, exp_cnt); end
    endtask

    task automatic test_alu;
        drive(1'b1, 6'h00, 32'h1234_5678, 32'h0, 32'h100, 5'd5, 1'b1, 2'b00);
        tick;
        n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL alu_reg_write: got %b want 1", reg_write); end
        n_cmp++; if (num_write !== 5'd5) begin n_bad++; $display("FAIL alu_num_write: got %0d want 5", num_write); end
        n_cmp++; if (data_write !== 32'h1234_5678) begin n_bad++; $display("FAIL alu_data: got %h want 12345678", data_write); end
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid); end
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        exp_cnt = exp_cnt + 32'd1;
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL alu_count: got %0d want %0d", retired_count, exp_cnt); end
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL alu_bubble_rw: got %b want 0", reg_write); end
        n_cmp++; if (data_write !== 32'h0) begin n_bad++; $display("FAIL alu_bubble_data: got %h want 0", data_write); end
    endtask

    task automatic test_loads;
        logic [5:0]  ops [6];
        logic [1:0]  offs[6];
        logic [31:0] exps[6];
        ops  = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h3F};
        offs = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2};
        exps = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], 32'h0000_1000 | {30'h0, offs[i]}, 32'h80FF_7F01, 32'h0,
                  5'(i + 1), 1'b1, 2'b01);
            tick;
            n_cmp++; if (data_write !== exps[i]) begin n_bad++; $display("FAIL load_%0d_data: got %h want %h", i, data_write, exps[i]); end
            n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL load_%0d_rw: got %b want 1", i, reg_write); end
        end
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        exp_cnt = exp_cnt + 32'd6;
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL load_count: got %0d want %0d", retired_count, exp_cnt); end
    endtask

    task automatic test_link_and_zero;
        drive(1'b1, 6'h03, 32'hDEAD_0000, 32'h0, 32'hFFFF_FFFC, 5'd31, 1'b1, 2'b10);
        tick;
        n_cmp++; if (data_write !== 32'h0000_0004) begin n_bad++; $display("FAIL link_data: got %h want 00000004", data_write); end
        n_cmp++; if (num_write !== 5'd31) begin n_bad++; $display("FAIL link_num: got %0d want 31", num_write); end
        drive(1'b1, 6'h00, 32'h5555_AAAA, 32'h0, 32'h0, 5'd3, 1'b1, 2'b11);
        tick;
        n_cmp++; if (data_write !== 32'h0) begin n_bad++; $display("FAIL reserved_data: got %h want 0", data_write); end
        drive(1'b1, 6'h00, 32'h77, 32'h0, 32'h0, 5'd0, 1'b1, 2'b00);
        tick;
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL zero_dst_rw: got %b want 0", reg_write); end
        n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL zero_dst_valid: got %b want 1", wb_valid); end
        drive(1'b1, 6'h2B, 32'h88, 32'h0, 32'h0, 5'd9, 1'b0, 2'b00);
        tick;
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL nowrite_rw: got %b want 0", reg_write); end
        n_cmp++; if (num_write !== 5'd9) begin n_bad++; $display("FAIL nowrite_num: got %0d want 9", num_write); end
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        exp_cnt = exp_cnt + 32'd4;
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL link_zero_count: got %0d want %0d", retired_count, exp_cnt); end
    endtask

    task automatic test_stall;
        int hi;
        hi = 0;
        drive(1'b1, 6'h00, 32'hAAAA_5555, 32'h0, 32'h0, 5'd6, 1'b1, 2'b00);
        tick;
        if (reg_write === 1'b1) hi++;
        stall = 1'b1;
        drive(1'b1, 6'h00, 32'h0000_BBBB, 32'h0, 32'h0, 5'd7, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick;
            if (reg_write === 1'b1) hi++;
            n_cmp++; if (num_write !== 5'd6) begin n_bad++; $display("FAIL stall_hold_num_%0d: got %0d want 6", i, num_write); end
        end
        n_cmp++; if (data_write !== 32'hAAAA_5555) begin n_bad++; $display("FAIL stall_hold_data: got %h want aaaa5555", data_write); end
        stall = 1'b0;
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        exp_cnt = exp_cnt + 32'd1;
        n_cmp++; if (hi !== 1) begin n_bad++; $display("FAIL stall_write_cycles: got %0d want 1", hi); end
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL stall_count: got %0d want %0d", retired_count, exp_cnt); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release_valid: got %b want 0", wb_valid); end
    endtask

    task automatic test_flush;
        drive(1'b1, 6'h00, 32'h42, 32'h0, 32'h0, 5'd8, 1'b1, 2'b00);
        tick;
        n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL flush_pre_rw: got %b want 1", reg_write); end
        stall = 1'b1; flush = 1'b1;
        tick;
        exp_cnt = exp_cnt + 32'd1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stall_valid: got %b want 0", wb_valid); end
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL flush_stall_rw: got %b want 0", reg_write); end
        stall = 1'b0;
        drive(1'b1, 6'h00, 32'h43, 32'h0, 32'h0, 5'd9, 1'b1, 2'b00);
        tick;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", wb_valid); end
        flush = 1'b0;
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL flush_count: got %0d want %0d", retired_count, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'h00, 32'hA0 + 32'(i), 32'h0, 32'h0, 5'(i + 1), 1'b1, 2'b00);
            tick;
            n_cmp++; if (num_write !== 5'(i + 1)) begin n_bad++; $display("FAIL b2b_%0d_num: got %0d want %0d", i, num_write, i + 1); end
            n_cmp++; if (data_write !== 32'hA0 + 32'(i)) begin n_bad++; $display("FAIL b2b_%0d_data: got %h want %h", i, data_write, 32'hA0 + 32'(i)); end
            n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL b2b_%0d_rw: got %b want 1", i, reg_write); end
        end
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        exp_cnt = exp_cnt + 32'd4;
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", retired_count, exp_cnt); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass;
        rs_num = 5'd7; rt_num = 5'd0; gpr_a = 32'h0; gpr_b = 32'h1234_5678;
        drive(1'b1, 6'h00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd7, 1'b1, 2'b00);
        tick;
        n_cmp++; if (a_fwd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL byp_a: got %h want deadbeef", a_fwd); end
        n_cmp++; if (b_fwd !== 32'h1234_5678) begin n_bad++; $display("FAIL byp_b_zero: got %h want 12345678", b_fwd); end
        rt_num = 5'd7;
        #1;
        n_cmp++; if (b_fwd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL byp_b: got %h want deadbeef", b_fwd); end
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        exp_cnt = exp_cnt + 32'd1;
        n_cmp++; if (a_fwd !== 32'h0) begin n_bad++; $display("FAIL byp_a_idle: got %h want 0", a_fwd); end
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL byp_count: got %0d want %0d", retired_count, exp_cnt); end
    endtask
`endif

    task automatic test_reset_mid_stall;
        drive(1'b1, 6'h00, 32'h99, 32'h0, 32'h0, 5'd10, 1'b1, 2'b00);
        tick;
        stall = 1'b1;
        tick;
        resetn = 1'b0;
        tick;
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall_valid: got %b want 0", wb_valid); end
        n_cmp++; if (retired_count !== 32'd0) begin n_bad++; $display("FAIL rst_stall_count: got %0d want 0", retired_count); end
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL rst_stall_rw: got %b want 0", reg_write); end
        resetn = 1'b1; stall = 1'b0;
        drive(1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00);
        tick;
        exp_cnt = 32'd0;
        n_cmp++; if (retired_count !== exp_cnt) begin n_bad++; $display("FAIL rst_stall_after: got %0d want %0d", retired_count, exp_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_cnt = 32'd0;
`ifdef WB_BYPASS_EN
        rs_num = 5'd0; rt_num = 5'd0; gpr_a = 32'h0; gpr_b = 32'h0;
`endif
        test_reset;
        test_alu;
        test_loads;
        test_link_and_zero;
        test_stall;
        test_flush;
        test_back_to_back;
`ifdef WB_BYPASS_EN
        test_bypass;
`endif
        test_reset_mid_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
